// File: rtl/baccarat_if.sv
// Card-datapath link for the baccarat controller: hand scores and the player third
// card come in, the six card-load strobes and the two win lights go out.
interface baccarat_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );
endinterface

// File: rtl/baccarat_fsm.sv
// Baccarat game sequencer: deals four cards, applies the natural and third-card
// rules on the datapath scores, then holds the win lights until reset.
module baccarat_fsm (
    input  logic        slow_clock,
    input  logic        reset,
    baccarat_if.master  bus
);

    typedef enum logic [3:0] {
        RST     = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        EVAL    = 4'd5,
        DEAL_P3 = 4'd6,
        EVAL_B  = 4'd7,
        DEAL_D3 = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] loads_q, loads_d;   // {p1, d1, p2, d2, p3, d3}
    logic       pwin_q, pwin_d;
    logic       dwin_q, dwin_d;

    // Face cards and tens count as zero; banker's tableau keyed on his score.
    function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] c3);
        logic [3:0] v;
        logic       draw;
        v = (c3 >= 4'd10) ? 4'd0 : c3;
        case (d)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    // Next-state selection and registered-output decode of the next state.
    always_comb begin
        state_d = state_q;
        loads_d = 6'b000000;
        pwin_d  = 1'b0;
        dwin_d  = 1'b0;

        case (state_q)
            RST:     state_d = DEAL_P1;
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = EVAL;
            EVAL: begin
                if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) begin
                    state_d = DONE;
                end else if (bus.pscore <= 4'd5) begin
                    state_d = DEAL_P3;
                end else if (bus.dscore <= 4'd5) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = DONE;
                end
            end
            DEAL_P3: state_d = EVAL_B;
            EVAL_B: begin
                if (banker_draws(bus.dscore, bus.pcard3)) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = DONE;
                end
            end
            DEAL_D3: state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RST;
        endcase

        // Outputs are registered, so decode the state being entered.
        case (state_d)
            DEAL_P1: loads_d = 6'b100000;
            DEAL_D1: loads_d = 6'b010000;
            DEAL_P2: loads_d = 6'b001000;
            DEAL_D2: loads_d = 6'b000100;
            DEAL_P3: loads_d = 6'b000010;
            DEAL_D3: loads_d = 6'b000001;
            default: loads_d = 6'b000000;
        endcase

        if (state_d == DONE) begin
            pwin_d = (bus.pscore >= bus.dscore);
            dwin_d = (bus.dscore >= bus.pscore);
        end else begin
            pwin_d = 1'b0;
            dwin_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge slow_clock) begin
        if (!reset) begin
            state_q <= RST;
            loads_q <= 6'b000000;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            loads_q <= loads_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
        end
    end

    assign bus.load_pcard1      = loads_q[5];
    assign bus.load_dcard1      = loads_q[4];
    assign bus.load_pcard2      = loads_q[3];
    assign bus.load_dcard2      = loads_q[2];
    assign bus.load_pcard3      = loads_q[1];
    assign bus.load_dcard3      = loads_q[0];
    assign bus.player_win_light = pwin_q;
    assign bus.dealer_win_light = dwin_q;

endmodule

// File: doc/baccarat_fsm.md
# baccarat_fsm

Control state machine for the baccarat card game. It sequences the six card-load strobes into the card datapath: four initial cards, then an optional third card for player and banker. It applies the natural and third-card drawing rules using the hand scores and player third card fed back from the datapath. It drives the two win lights, then holds the result until reset.

## Interface
Parameters: none.

- slow_clock  input  1  game clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-low; the same reset clears the datapath card registers
- pscore  input  4  player hand score 0–9, from datapath
- dscore  input  4  banker hand score 0–9, from datapath
- pcard3  input  4  player third card rank (0 = none, 1–13 = A..K), from datapath
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load strobes
- load_dcard1, load_dcard2, load_dcard3  output  1 each  banker card load strobes
- player_win_light  output  1  player wins (or tie)
- dealer_win_light  output  1  banker wins (or tie)

## Operation
- States: RST, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, EVAL_B, DEAL_D3, DONE.
- Moore decode. Each DEAL_x state asserts exactly its one load strobe. Every other state asserts no load strobe.
- reset low at a rising edge → RST, regardless of current state. RST → DEAL_P1 on the first edge with reset high.
- Fixed order: DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → EVAL.
- EVAL, evaluated in this priority:
  - pscore ≥ 8 or dscore ≥ 8 (natural) → DONE.
  - pscore ≤ 5 → DEAL_P3.
  - pscore 6–7 and dscore ≤ 5 → DEAL_D3.
  - otherwise → DONE.
- DEAL_P3 → EVAL_B.
- EVAL_B: third-card value v = 0 if pcard3 ≥ 10, else pcard3. Banker draws (→ DEAL_D3) when any of these holds:
  - dscore ≤ 2
  - dscore = 3 and v ≠ 8
  - dscore = 4 and v in 2–7
  - dscore = 5 and v in 4–7
  - dscore = 6 and v in 6–7
  
  Otherwise → DONE. dscore = 7 always stands.
- DEAL_D3 → DONE.
- DONE is absorbing until reset. Lights are 0 in all other states. In DONE:
  - player_win_light = (pscore ≥ dscore)
  - dealer_win_light = (dscore ≥ pscore)
  - A tie lights both.
- Score inputs with values above 9 are out of contract. Compare as unsigned 4-bit.

## Timing
- Reset values: state RST, all six load strobes 0, both lights 0.
- Load strobes are high for exactly one full slow_clock cycle. The datapath captures the card on the falling edge inside that cycle, so pscore, dscore and pcard3 are valid at the next rising edge. Decisions in EVAL and EVAL_B, and the DONE lights, use those settled values.
- Cycle numbering: cycle 1 = first cycle after reset release.
  - Cycles 1–4: P1, D1, P2, D2 strobes.
  - Cycle 5: EVAL.
- Path lengths (first DONE cycle):
  - Natural, or both stand: cycle 6.
  - Player stands, banker draws: DEAL_D3 in cycle 6, DONE in cycle 7.
  - Player draws, banker stands: DEAL_P3 in 6, EVAL_B in 7, DONE in 8.
  - Player draws, banker draws: DEAL_P3 in 6, EVAL_B in 7, DEAL_D3 in 8, DONE in 9.
- Reset asserted mid-game, including during a DEAL state: the strobe drops after that edge. No partial sequence resumes; the game restarts at DEAL_P1 after release.
- No strobe is ever asserted twice per game. At most one strobe is high in any cycle.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset. load_pcard1..load_dcard2 high in cycles 1–4 respectively, one-hot.
- Natural, scores after cycle 4 pscore=8, dscore=3 → no third-card strobes, DONE in cycle 6, player_win_light=1, dealer_win_light=0.
- pscore=4, dscore=5, pcard3=4 (v=4) → load_pcard3 in cycle 6, load_dcard3 in cycle 8. Then with final pscore=7, dscore=7 → both lights 1 in cycle 9.
- pscore=3, dscore=6, pcard3=12 (v=0) → load_pcard3 in cycle 6, banker stands, DONE in cycle 8. Final pscore=3 vs dscore=6 → dealer_win_light=1 only.
- pscore=6, dscore=2 → load_dcard3 in cycle 6, DONE in cycle 7. Final dscore=9 → dealer_win_light=1 only.
- Reset asserted during DEAL_P3 (cycle 6) → at the next edge all strobes and lights are 0. After release, load_pcard1 is asserted again in cycle 1 and the full sequence repeats.
